// File: rtl/instruction_memory_arbiter.sv
// Shared instruction memory with round-robin fetch arbitration.
// Program writes take priority over CPU fetches.
module instruction_memory_arbiter #(
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int NUM_PORTS         = 4,
  parameter int COUNT_WIDTH       = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PORTS-1:0]                   memory_valid,
  input  logic [NUM_PORTS*MEMORY_ADDR_WIDTH-1:0] memory_addr,
  output logic [NUM_PORTS-1:0]                   memory_ready,
  output logic [NUM_PORTS*MEMORY_WIDTH-1:0]      memory_data,
  input  logic                                   wr_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0]           wr_addr,
  input  logic [MEMORY_WIDTH-1:0]                wr_data,
  output logic [COUNT_WIDTH-1:0]                 fetch_count
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEPTH = 2 ** MEMORY_ADDR_WIDTH;
  localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] rd_port;
  logic          grant_any;
  logic          rd_pend;
  logic [MEMORY_ADDR_WIDTH-1:0] grant_addr;
  logic [MEMORY_WIDTH-1:0] rd_q;
  logic [MEMORY_WIDTH-1:0] hold [NUM_PORTS];
  logic [MEMORY_WIDTH-1:0] mem [DEPTH];

  always_comb begin
    int p;
    p = 0;
    grant_any = 1'b0;
    grant_idx = ptr;
    if (rst && !wr_valid) begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        p = (int'(ptr) + k) % NUM_PORTS;
        if (!grant_any && memory_valid[p]) begin
          grant_any = 1'b1;
          grant_idx = PW'(p);
        end
      end
    end
    memory_ready = NUM_PORTS'(grant_any) << grant_idx;
  end

  assign grant_addr =
    memory_addr[grant_idx*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];

  // Contents survive reset; a write never shares a cycle with a read.
  always_ff @(posedge clk) begin
    if (wr_valid) begin
      mem[wr_addr] <= wr_data;
    end else if (grant_any) begin
      rd_q <= mem[grant_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= LAST;
      rd_pend     <= 1'b0;
      rd_port     <= '0;
      fetch_count <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        hold[i] <= '0;
      end
    end else begin
      rd_pend <= grant_any;
      if (grant_any) begin
        ptr     <= grant_idx;
        rd_port <= grant_idx;
        if (fetch_count != '1) begin
          fetch_count <= fetch_count + COUNT_WIDTH'(1);
        end
      end
      if (rd_pend) begin
        hold[rd_port] <= rd_q;
      end
    end
  end

  // Freshly read word bypasses the lane hold register for one cycle.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      memory_data[i*MEMORY_WIDTH +: MEMORY_WIDTH] =
        (rd_pend && rd_port == PW'(i)) ? rd_q : hold[i];
    end
  end

endmodule

// File: tb/tb_instruction_memory_arbiter.sv
// Randomized bench with a behavioural model of the shared
// instruction memory, plus directed literal checks.
module tb_instruction_memory_arbiter;

  localparam int W  = 16;
  localparam int AW = 11;
  localparam int N  = 4;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    mv;
  logic [N*AW-1:0] ma;
  logic [N-1:0]    mr, mr4;
  logic [N*W-1:0]  md, md4;
  logic            wv;
  logic [AW-1:0]   wa;
  logic [W-1:0]    wd;
  logic [CW-1:0]   fc;
  logic [3:0]      fc4;

  always #5 clk = ~clk;

  instruction_memory_arbiter #(
    .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW),
    .NUM_PORTS(N), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .memory_valid(mv), .memory_addr(ma),
    .memory_ready(mr), .memory_data(md),
    .wr_valid(wv), .wr_addr(wa), .wr_data(wd),
    .fetch_count(fc)
  );

  instruction_memory_arbiter #(
    .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW),
    .NUM_PORTS(N), .COUNT_WIDTH(4)
  ) dut4 (
    .clk(clk), .rst(rst),
    .memory_valid(mv), .memory_addr(ma),
    .memory_ready(mr4), .memory_data(md4),
    .wr_valid(wv), .wr_addr(wa), .wr_data(wd),
    .fetch_count(fc4)
  );

  logic [W-1:0] m_mem [0:2047];
  logic [W-1:0] m_lane [N];
  int           m_ptr;
  longint       m_cnt;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    m_ptr = N - 1;
    m_cnt = 0;
    for (int i = 0; i < N; i++) m_lane[i] = '0;
  endtask

  function automatic int exp_grant();
    int p;
    if (rst !== 1'b1 || wv) return -1;
    for (int k = 1; k <= N; k++) begin
      p = (m_ptr + k) % N;
      if (mv[p]) return p;
    end
    return -1;
  endfunction

  task automatic set_port(int p, int a);
    ma[p*AW +: AW] = AW'(a);
  endtask

  task automatic check_outputs();
    longint sat;
    sat = (m_cnt > 15) ? 15 : m_cnt;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("lane%0d", i), md[i*W +: W], m_lane[i]);
      chk($sformatf("lane%0d_c4", i), md4[i*W +: W], m_lane[i]);
    end
    chk("fetch_count", fc, m_cnt);
    chk("fetch_count_c4", fc4, sat);
  endtask

  // One clock: check grant before the edge, advance model, check data after.
  task automatic cycle(output logic [N-1:0] got);
    int g;
    logic [63:0] e;
    g = exp_grant();
    e = (g < 0) ? 64'd0 : (64'd1 << g);
    #2;
    got = mr;
    chk("memory_ready", mr, e);
    chk("memory_ready_c4", mr4, e);
    @(posedge clk);
    if (rst) begin
      if (wv) m_mem[wa] = wd;
      else if (g >= 0) begin
        m_lane[g] = m_mem[ma[g*AW +: AW]];
        m_ptr = g;
        m_cnt++;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    mv = '0;
    wv = 1'b0;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [N-1:0] got;

  initial begin
    rst = 1'b0;
    mv = '1;
    ma = '0;
    wv = 1'b0;
    wa = '0;
    wd = '0;
    model_reset();
    cycle(got);
    chk("reset_ready_lit", got, 0);
    chk("reset_count_lit", fc, 0);
    mv = '0;
    rst = 1'b1;

    wv = 1'b1;
    for (int a = 0; a < 128; a++) begin
      wa = AW'(a);
      if (a < 4) wd = W'(16'hA000 + a);
      else if (a == 7) wd = 16'h00FF;
      else wd = W'($urandom);
      cycle(got);
    end
    wv = 1'b0;
    do_reset();

    // load then single fetch
    wv = 1'b1; wa = 11'd110; wd = 16'h2A5C;
    cycle(got);
    wv = 1'b0;
    mv = 4'b0100;
    set_port(2, 110);
    cycle(got);
    chk("single_ready_lit", got, 4'b0100);
    mv = '0;
    chk("single_lane2_lit", md[2*W +: W], 16'h2A5C);
    chk("single_count_lit", fc, 1);

    // asynchronous reset while port 1 is granted
    mv = 4'b0010;
    set_port(1, 20);
    #2;
    chk("pre_rst_ready_lit", mr, 4'b0010);
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_ready_lit", mr, 0);
    chk("async_lanes_lit", md, 0);
    chk("async_count_lit", fc, 0);
    chk("async_count_c4_lit", fc4, 0);
    mv = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mv = 4'b0011;
    set_port(0, 1);
    set_port(1, 2);
    cycle(got);
    chk("post_rst_first_lit", got, 4'b0001);
    mv = 4'b0010;
    cycle(got);
    chk("post_rst_second_lit", got, 4'b0010);
    mv = '0;
    do_reset();

    // round robin from reset
    mv = 4'b1111;
    for (int i = 0; i < N; i++) set_port(i, i);
    for (int i = 0; i < 5; i++) begin
      cycle(got);
      chk("rr_grant_lit", got, 4'b0001 << (i % 4));
      chk("rr_lane_lit", md[(i%4)*W +: W], 16'hA000 + (i % 4));
    end
    mv = '0;

    // write priority and read-after-write
    mv = 4'b0010;
    set_port(1, 5);
    wv = 1'b1; wa = 11'd6; wd = W'($urandom);
    cycle(got);
    chk("wp_ready0_lit", got, 0);
    wa = 11'd5; wd = 16'h1234;
    cycle(got);
    chk("wp_ready1_lit", got, 0);
    wv = 1'b0;
    cycle(got);
    chk("wp_grant_lit", got, 4'b0010);
    mv = '0;
    chk("wp_raw_lit", md[W +: W], 16'h1234);

    // lane hold
    mv = 4'b1000;
    set_port(3, 7);
    cycle(got);
    chk("hold_grant_lit", got, 4'b1000);
    mv = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      set_port(0, $urandom_range(0, 127));
      cycle(got);
      chk("hold_lane3_lit", md[3*W +: W], 16'h00FF);
    end
    mv = '0;

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) do_reset();
      for (int p = 0; p < N; p++) begin
        if (!mv[p] && $urandom_range(0, 2) == 0) begin
          mv[p] = 1'b1;
          set_port(p, $urandom_range(0, 127));
        end
      end
      wv = ($urandom_range(0, 7) == 0);
      wa = AW'($urandom_range(0, 127));
      wd = W'($urandom);
      cycle(got);
      for (int p = 0; p < N; p++) begin
        if (got[p]) begin
          if ($urandom_range(0, 1) == 0) mv[p] = 1'b0;
          else set_port(p, $urandom_range(0, 127));
        end
      end
    end
    mv = '0;
    wv = 1'b0;

    // saturation of the narrow counter
    chk("sat_lit", fc4, 4'hF);
    mv = 4'b0001;
    set_port(0, 3);
    cycle(got);
    chk("sat_stays_lit", fc4, 4'hF);
    mv = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_memory_arbiter.md
# instruction_memory_arbiter

Shared instruction memory that answers instruction fetches from several `regex_cpu_pipelined` instances. It arbitrates round-robin among the CPU fetch ports and reads a single-port synchronous memory. Each granted fetch returns its instruction word one cycle later on that port's data lane. A load port lets the host write the compiled regex program before and between runs. The block sits between the CPU array and the program-loading logic.

## Interface
- `MEMORY_WIDTH`, 16, instruction word width.
- `MEMORY_ADDR_WIDTH`, 11, word address width; depth is 2**`MEMORY_ADDR_WIDTH`.
- `NUM_PORTS`, 4, number of CPU fetch ports (≥1).
- `COUNT_WIDTH`, 32, width of the fetch statistics counter.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `memory_valid`  in  `NUM_PORTS`  per-port fetch request; CPU holds it and the address stable until accepted.
- `memory_addr`  in  `NUM_PORTS`*`MEMORY_ADDR_WIDTH`  packed per-port fetch addresses; port i occupies slice i.
- `memory_ready`  out  `NUM_PORTS`  per-port grant; one-hot or zero.
- `memory_data`  out  `NUM_PORTS`*`MEMORY_WIDTH`  packed per-port instruction words.
- `wr_valid`  in  1  program write strobe.
- `wr_addr`  in  `MEMORY_ADDR_WIDTH`  write address.
- `wr_data`  in  `MEMORY_WIDTH`  write data.
- `fetch_count`  out  `COUNT_WIDTH`  number of granted fetches, saturating.

## Operation
- Transfer on port i: `memory_valid[i]` && `memory_ready[i]` at a rising edge.
- `memory_ready` is combinational from `memory_valid`, `wr_valid` and the round-robin pointer.
- CPUs must not make `memory_valid` depend on `memory_ready`.
- Writes have priority. When `wr_valid`=1, all `memory_ready` bits are 0 and the write commits at that edge. There is no write back-pressure.
- When `wr_valid`=0, the grant goes to the first port with `memory_valid` set, searching from `ptr+1` upward modulo `NUM_PORTS`.
- `ptr` updates to the granted port index on every grant. With no grant, `ptr` holds.
- At most one read per cycle. The memory is read at the granted address on the grant edge.
- The read word is registered into lane g of `memory_data` (g = granted port). The lane holds that value until port g's next grant completes; other lanes are unaffected.
- Read-after-write: a read granted the cycle after a write to the same address returns the new data. A read is never granted in the same cycle as a write.
- `fetch_count` increments by 1 per grant and saturates at all-ones.
- Memory contents are not reset; they are undefined until written.

## Timing
- Reset (`rst`=0, asynchronous):
  - `ptr` = `NUM_PORTS`-1, so port 0 has highest priority first.
  - All `memory_data` lanes = 0.
  - `fetch_count` = 0.
  - `memory_ready` = 0 while `rst`=0, regardless of inputs.
- Deassertion is sampled at the next rising edge.
- Reset mid-fetch: a fetch granted at or before the reset edge does not deliver data; its lane reads 0. The CPU must re-request.
- Grant latency: if the port is idle and wins arbitration, `memory_ready` is asserted in the same cycle `memory_valid` rises.
- Data latency: `memory_data` lane is valid in the cycle immediately after the transfer edge. Matching CPU behaviour: CPU drops `memory_valid` after the transfer and consumes data the next cycle.
- Fairness under continuous requests from all ports: grants rotate 0,1,2,…,`NUM_PORTS`-1,0,…, one per cycle. Worst-case wait is `NUM_PORTS`-1 cycles plus any write cycles.
- A port that keeps `memory_valid` high after its transfer is treated as a new request. It is lowest priority in the next cycle.
- `NUM_PORTS`=1: the pointer is constant and the port is granted whenever `memory_valid`=1 and `wr_valid`=0.

## Test plan
- Load then single fetch:
  - Stimulus: write 0x2A5C to addr 110; next cycle raise `memory_valid[2]` at addr 110.
  - Response: `memory_ready`=4'b0100 that cycle; lane 2 = 0x2A5C the following cycle; `fetch_count`=1.
- Round-robin after reset:
  - Stimulus: ports 0–3 all request continuously at addrs 0..3, holding 0xA000+addr.
  - Response: grants 0,1,2,3,0 on consecutive cycles; each lane shows 0xA000+i one cycle after its grant.
- Write priority:
  - Stimulus: `wr_valid`=1 for 2 cycles while port 1 requests addr 5.
  - Response: `memory_ready`=0 for both cycles; grant in cycle 3.
  - Stimulus: a write of 0x1234 to addr 5 in the last write cycle.
  - Response: that fetch returns 0x1234.
- Lane hold:
  - Stimulus: grant port 3 (data 0x00FF), then 10 cycles of grants to port 0 only.
  - Response: lane 3 stays 0x00FF throughout.
- Asynchronous reset mid-operation:
  - Stimulus: assert `rst`=0 between edges while port 1 is granted.
  - Response: `memory_ready`=0 and all lanes 0 immediately, without waiting for an edge; `fetch_count`=0.
  - Stimulus: after release, ports 0 and 1 request.
  - Response: port 0 is granted first.
- Saturation:
  - Stimulus: `COUNT_WIDTH`=4; perform 20 grants.
  - Response: `fetch_count` reads 15 and stays there.
